demux_buffered: RTL and testbench

Buffered 1-to-2 demultiplexer on 16-bit datapath words: steers each accepted input word to output 0 or output 1 by a select bit and holds it in a small per-output FIFO until that destination takes it. It is the steering counterpart of the datapath 2:1 mux. It splits one producer stream between two consumers so that a stalled consumer never blocks traffic to the other, except when the stalled side's FIFO is full.

---
 rtl/demux_pkg.sv | 13 +
 rtl/demux_fifo.sv | 71 +++++++
 rtl/demux_buffered.sv | 69 ++++++
 tb/tb_demux_buffered.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the buffered 1-to-2 demultiplexer.
package demux_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

  typedef enum logic {
    SEL_OUT0 = 1'b0,
    SEL_OUT1 = 1'b1
  } sel_e;

endpackage

// File: rtl/demux_fifo.sv
// Per-output FIFO: registered storage, head/tail pointers and occupancy count.
module demux_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[head_q];

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // Full/empty come from registered count, so a same-cycle pop never frees a slot for a push.
    do_push = push && !full;
    do_pop  = pop && !empty;
    if (do_push) begin
      mem_d[tail_q] = push_data;
      tail_d        = tail_q + PTR_ONE;
    end
    if (do_pop) begin
      head_d = head_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/demux_buffered.sv
// Buffered 1-to-2 demultiplexer: steers each accepted word into one of two
// independent FIFOs by in_select; a stalled output only blocks its own side.
module demux_buffered
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_select,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out0_data,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [WIDTH-1:0]       out1_data,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [$clog2(DEPTH):0] out0_count,
  output logic [$clog2(DEPTH):0] out1_count
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;
  logic accept;

  // in_ready depends only on in_select and registered occupancy.
  assign in_ready = (in_select == SEL_OUT1) ? !full1 : !full0;
  assign accept   = in_valid && in_ready;
  assign push0    = accept && (in_select == SEL_OUT0);
  assign push1    = accept && (in_select == SEL_OUT1);

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .full      (full0),
    .pop       (out0_ready),
    .head_data (out0_data),
    .empty     (empty0),
    .count     (out0_count)
  );

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .full      (full1),
    .pop       (out1_ready),
    .head_data (out1_data),
    .empty     (empty1),
    .count     (out1_count)
  );

endmodule

// File: tb/tb_demux_buffered.sv
// Bench for demux_buffered: directed steps then constrained-random traffic,
// checked against a queue-based model of the two destination FIFOs.
module tb_demux_buffered;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_select;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [1:0]  out0_count;
  logic [1:0]  out1_count;

  int total = 0;
  int bad   = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        last_acc = 1'b0;

  demux_buffered #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_select  (in_select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out0_count (out0_count),
    .out1_count (out1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs();
    chk("out0_valid", out0_valid, q0.size() > 0);
    chk("out1_valid", out1_valid, q1.size() > 0);
    chk("out0_count", out0_count, q0.size());
    chk("out1_count", out1_count, q1.size());
    if (q0.size() > 0) chk("out0_data", out0_data, q0[0]);
    if (q1.size() > 0) chk("out1_data", out1_data, q1[0]);
  endtask

  task automatic check_reset_state();
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_count", out0_count, 0);
    chk("rst_out1_count", out1_count, 0);
    chk("rst_out0_data", out0_data, 0);
    chk("rst_out1_data", out1_data, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  // One clock cycle: drive inputs, check in_ready, clock, update model, check outputs.
  task automatic cyc(input logic v, input logic s, input logic [15:0] d,
                     input logic r0, input logic r1);
    logic exp_rdy, acc, p0, p1;
    in_valid   = v;
    in_select  = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    exp_rdy = (s ? q1.size() : q0.size()) < DEPTH;
    chk("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy;
    p0  = r0 && (q0.size() > 0);
    p1  = r1 && (q1.size() > 0);
    @(posedge clk);
    #1;
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (acc) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
    end
    last_acc = acc;
    check_outs();
  endtask

  initial begin
    logic        v, s, r0, r1;
    logic [15:0] d;

    in_valid = 0; in_select = 0; in_data = '0; out0_ready = 0; out1_ready = 0;
    rst_n = 0;
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    rst_n = 1;

    // First accept after reset release, no bypass to output.
    cyc(1, 0, 16'h1234, 0, 0);
    chk("first_out0_data", out0_data, 16'h1234);
    chk("first_out0_count", out0_count, 1);
    chk("first_out1_valid", out1_valid, 0);

    // Fill output 1; output 0 stays accepting.
    cyc(1, 1, 16'hA001, 0, 0);
    cyc(1, 1, 16'hA002, 0, 0);
    chk("fill_out1_count", out1_count, 2);
    cyc(1, 1, 16'hA003, 0, 0);
    chk("full_refuse_acc", last_acc, 0);
    cyc(1, 0, 16'h5555, 0, 0);
    chk("other_side_acc", out0_count, 2);

    // Drain output 0, then stream 1..8 through it with pops every cycle.
    cyc(0, 0, 16'h0, 1, 0);
    cyc(0, 0, 16'h0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 16'(i), 1, 0);
      if (i > 1) chk("stream_count", out0_count, 1);
    end
    cyc(0, 0, 16'h0, 1, 0);
    chk("stream_drained", out0_valid, 0);

    // Push and pop together at count 1.
    cyc(1, 0, 16'h1111, 0, 0);
    cyc(1, 0, 16'hBEEF, 1, 0);
    chk("pushpop_count", out0_count, 1);
    chk("pushpop_head", out0_data, 16'hBEEF);

    // Full FIFO with a pop: push refused this cycle, accepted the next.
    cyc(1, 1, 16'hC0DE, 0, 1);
    chk("fullpop_refused", last_acc, 0);
    cyc(1, 1, 16'hC0DE, 0, 0);
    chk("fullpop_next_acc", last_acc, 1);
    chk("fullpop_count", out1_count, 2);

    // Asynchronous reset mid-operation with both FIFOs holding data.
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    check_reset_state();
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst_n = 1;

    // Random traffic; a pending unaccepted word is held stable.
    v = 0; s = 0; d = '0;
    last_acc = 0;
    for (int n = 0; n < 400; n++) begin
      if (!(v && !last_acc)) begin
        v = ($urandom_range(3) != 0);
        s = $urandom_range(1);
        d = 16'($urandom);
      end
      r0 = ($urandom_range(2) != 0);
      r1 = ($urandom_range(3) == 0);
      cyc(v, s, d, r0, r1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
